ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port halt  input  1  request to park the core before next fetch.
REQ-005 SHALL have port imem_req / imem_ack  output / input  1 / 1  instruction fetch handshake.
REQ-006 SHALL have port dmem_req / dmem_ack  output / input  1 / 1  data access handshake.
REQ-007 SHALL have port dmem_we  output  1  data access is a store.
REQ-008 SHALL have port decode_next  input  3  next state from decode stage (FETCH for nop, else EXE).
REQ-009 SHALL have ports is_load, is_store, wr_rd  input  1 each  class of current instruction.
REQ-010 SHALL have port state_reg  output  3  current state: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-011 SHALL have ports ir_en, pc_en, reg_wr_en, retire  output  1 each  datapath strobes.
REQ-012 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-013 SHALL drive imem_req=1 in FETCH except when halt=1 and no fetch pending; once asserted, imem_req SHALL hold until the cycle imem_ack=1.
REQ-014 FETCH with halt=1 and no fetch pending SHALL go to HALT next cycle; HALT SHALL return to FETCH the cycle after halt=0.
REQ-015 FETCH with imem_ack=1 SHALL pulse ir_en for that cycle and go to DECODE; imem_ack outside a pending request SHALL be ignored.
REQ-016 DECODE SHALL last exactly one cycle; next state = FETCH if decode_next=0, else EXE (any value other than 0 treated as EXE).
REQ-017 DECODE with decode_next=0 (nop) SHALL pulse pc_en and retire in that cycle; reg_wr_en SHALL stay 0.
REQ-018 EXE SHALL last one cycle; next = MEM if is_load|is_store, else WB.
REQ-019 MEM SHALL assert dmem_req, with dmem_we=is_store, from entry until dmem_ack=1; on ack go to WB.
REQ-020 WB SHALL last one cycle: reg_wr_en=wr_rd & !is_store, pc_en=1, retire=1; next FETCH.
REQ-021 dmem_req, dmem_we SHALL be 0 outside MEM; ir_en 0 outside FETCH; reg_wr_en 0 outside WB.
REQ-022 instret SHALL increment by 1 on each retire pulse, wrapping from 2^CNT_W-1 to 0.
REQ-023 halt SHALL never abort a pending fetch, a MEM access, or an instruction past FETCH; it takes effect only at the next FETCH with no pending request.
REQ-024 Fetch latency with single-cycle ack: non-memory instruction = 4 cycles (FETCH, DECODE, EXE, WB); memory op = 5 + extra MEM wait cycles; nop = 2 cycles.

Reset
REQ-025 rst=0 SHALL immediately force state FETCH, fetch-pending flag 0, instret 0, and all strobe/request outputs 0 regardless of clk.
REQ-026 imem_req SHALL be first asserted in the first cycle after rst deasserts (halt=0); reset mid-handshake SHALL drop imem_req/dmem_req with no retire.

Verification
REQ-027 Reset release, halt=0, imem_ack=1 next cycle, decode_next=2, is_load=is_store=0, wr_rd=1 -> states 0,1,2,4,0; reg_wr_en, pc_en, retire one cycle in WB; instret=1.
REQ-028 Nop: decode_next=0 -> states 0,1,0; pc_en and retire in DECODE, reg_wr_en never 1; instret increments.
REQ-029 Store with dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=1; WB reg_wr_en=0.
REQ-030 halt=1 during pending fetch -> imem_req held until ack, instruction completes, then HALT (state 5) with imem_req=0; halt=0 -> FETCH next cycle.
REQ-031 CNT_W=4, 16 retires -> instret wraps 15 to 0.
REQ-032 rst pulled low in MEM with dmem_req=1 -> dmem_req=0, state=0, instret=0 asynchronously.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multi-cycle core control FSM: fetch/decode/execute/memory/writeback
// sequencing with halt parking and a retired-instruction counter.
module ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             dmem_we,
    input  logic [2:0]       decode_next,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             wr_rd,
    output logic [2:0]       state_reg,
    output logic             ir_en,
    output logic             pc_en,
    output logic             reg_wr_en,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pend;
    logic   pend_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            pend    <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    // A request left unacknowledged stays owed, so halt cannot cancel it.
    always_comb begin
        state_nxt = state;
        pend_nxt  = 1'b0;
        unique case (state)
            FETCH: begin
                if (imem_req) begin
                    if (imem_ack)
                        state_nxt = DECODE;
                    else
                        pend_nxt = 1'b1;
                end else begin
                    state_nxt = HALT;
                end
            end
            DECODE: begin
                if (decode_next == 3'd0)
                    state_nxt = FETCH;
                else
                    state_nxt = EXE;
            end
            EXE: begin
                if (is_load | is_store)
                    state_nxt = MEM;
                else
                    state_nxt = WB;
            end
            MEM: begin
                if (dmem_ack)
                    state_nxt = WB;
            end
            WB: state_nxt = FETCH;
            HALT: begin
                if (!halt)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes are gated by rst so they drop as soon as reset asserts.
    always_comb begin
        imem_req  = 1'b0;
        ir_en     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_en     = 1'b0;
        retire    = 1'b0;
        reg_wr_en = 1'b0;
        if (rst) begin
            unique case (state)
                FETCH: begin
                    imem_req = pend | ~halt;
                    ir_en    = imem_req & imem_ack;
                end
                DECODE: begin
                    if (decode_next == 3'd0) begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                WB: begin
                    reg_wr_en = wr_rd & ~is_store;
                    pc_en     = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_reg = state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed + randomized bench for ctrl_fsm; expected per-cycle traces are
// built from instruction class and handshake delays.
module tb_ctrl_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             halt;
    logic             imem_req;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_ack;
    logic             dmem_we;
    logic [2:0]       decode_next;
    logic             is_load;
    logic             is_store;
    logic             wr_rd;
    logic [2:0]       state_reg;
    logic             ir_en;
    logic             pc_en;
    logic             reg_wr_en;
    logic             retire;
    logic [CNT_W-1:0] instret;

    int n_pass = 0;
    int n_total = 0;
    int retired = 0;

    ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_we(dmem_we),
        .decode_next(decode_next), .is_load(is_load),
        .is_store(is_store), .wr_rd(wr_rd), .state_reg(state_reg),
        .ir_en(ir_en), .pc_en(pc_en), .reg_wr_en(reg_wr_en),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle with its expected observable behaviour.
    task automatic step(input int st, input bit ireq, input bit ir,
                        input bit dreq, input bit dwe, input bit rwe,
                        input bit pc, input bit ret);
        #1;
        chk("state", 32'(state_reg), 32'(st));
        chk("imem_req", 32'(imem_req), 32'(ireq));
        chk("ir_en", 32'(ir_en), 32'(ir));
        chk("dmem_req", 32'(dmem_req), 32'(dreq));
        chk("dmem_we", 32'(dmem_we), 32'(dwe));
        chk("reg_wr_en", 32'(reg_wr_en), 32'(rwe));
        chk("pc_en", 32'(pc_en), 32'(pc));
        chk("retire", 32'(retire), 32'(ret));
        chk("instret", 32'(instret), 32'(retired % (1 << CNT_W)));
        @(posedge clk);
        #1;
        if (ret) retired++;
    endtask

    // cls: 0 nop, 1 alu, 2 load, 3 store
    task automatic run_instr(input int di, input int cls, input bit wr,
                             input int dm, input bit halt_mid);
        bit st;
        st = (cls == 3);
        is_load = (cls == 2);
        is_store = st;
        wr_rd = wr;
        decode_next = (cls == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        for (int k = 0; k < di; k++) begin
            imem_ack = 1'b0;
            step(0, 1, 0, 0, 0, 0, 0, 0);
            if (halt_mid) halt = 1'b1;
        end
        imem_ack = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0, 0);
        imem_ack = 1'b0;
        if (cls == 0) begin
            step(1, 0, 0, 0, 0, 0, 1, 1);
            return;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        if (cls >= 2) begin
            for (int k = 0; k < dm; k++) begin
                dmem_ack = 1'b0;
                step(3, 0, 0, 1, st, 0, 0, 0);
            end
            dmem_ack = 1'b1;
            step(3, 0, 0, 1, st, 0, 0, 0);
            dmem_ack = 1'b0;
        end
        step(4, 0, 0, 0, 0, wr & ~st, 1, 1);
    endtask

    initial begin
        rst = 1'b0;
        halt = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        decode_next = 3'd0;
        is_load = 1'b0;
        is_store = 1'b0;
        wr_rd = 1'b0;
        #2;
        chk("rst_state", 32'(state_reg), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU op, ack on first fetch cycle: states 0,1,2,4
        run_instr(0, 1, 1, 0, 0);
        // nop: states 0,1
        run_instr(0, 0, 1, 0, 0);
        // store with 3-cycle dmem delay
        run_instr(1, 3, 1, 3, 0);
        // load with delayed ack
        run_instr(2, 2, 1, 2, 0);

        // halt raised while a fetch is owed
        run_instr(2, 1, 1, 0, 1);
        imem_ack = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        imem_ack = 1'b0;
        step(5, 0, 0, 0, 0, 0, 0, 0);
        step(5, 0, 0, 0, 0, 0, 0, 0);
        halt = 1'b0;
        step(5, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 1, 0, 0, 0);

        // randomized traffic; CNT_W=4 forces several wraps
        for (int i = 0; i < 60; i++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), $urandom_range(0, 3), 0);

        // asynchronous reset in the middle of a memory access
        is_load = 1'b1;
        is_store = 1'b0;
        decode_next = 3'd2;
        imem_ack = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0, 0);
        imem_ack = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("mem_req_pre", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_reg), 32'd0);
        chk("arst_dmem_req", 32'(dmem_req), 32'd0);
        chk("arst_instret", 32'(instret), 32'd0);
        chk("arst_retire", 32'(retire), 32'd0);
        retired = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr(1, 3, 1, 1, 0);
        run_instr(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
